rom_load_seq: RTL
=================

ROM_LOAD_SEQ -- requirements
Module: rom_load_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 4096: clk_sys cycles core_reset stays high after a download or reset request ends.
REQ-002 Parameter ROM_SIZE, default 16'hD400: exact byte count a valid ROM download must deliver.
REQ-003 Signal clk_sys, input, 1: sole clock, 12 MHz system domain.
REQ-004 Signal reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Signal ioctl_download, input, 1: download session active.
REQ-006 Signal ioctl_index, input, 8: download target; only 8'h00 is ROM.
REQ-007 Signal ioctl_wr, input, 1: one-cycle byte strobe.
REQ-008 Signal ioctl_addr, input, 25: byte address.
REQ-009 Signal ioctl_dout, input, 8: byte data.
REQ-010 Signal rst_req, input, 1: level request for a user reset (OSD or button).
REQ-011 Signal dn_addr, output, 16: region-relative write address.
REQ-012 Signal dn_data, output, 8: write data.
REQ-013 Signal dn_we, output, 5: one-hot region write enable {prom, sprite, char, sound, cpu}.
REQ-014 Signal core_reset, output, 1: active-high reset to the game core.
REQ-015 Signal load_done, output, 1: a valid ROM image is loaded.
REQ-016 Signal load_err, output, 1: last download was malformed; sticky.

Function
REQ-017 States: IDLE (nothing loaded), LOAD, HOLD, RUN, ERR.
REQ-018 A download starts on a rising edge of ioctl_download with ioctl_index==0; from any state it enters LOAD, clears the byte counter, load_done and load_err.
REQ-019 A download with ioctl_index!=0 is ignored and causes no state change.
REQ-020 In LOAD, each ioctl_wr with ioctl_addr[24:16]==0 is decoded by region and registered; dn_we, dn_addr and dn_data appear exactly 1 cycle later, with dn_we high for 1 cycle.
REQ-021 Region map, absolute address: cpu 0000-5FFF, sound 6000-6FFF, char 7000-8FFF, sprite 9000-CFFF, prom D000-D3FF; dn_addr = ioctl_addr - region base.
REQ-022 A write at or above ROM_SIZE, or with ioctl_addr[24:16]!=0, produces no dn_we and sets an overflow flag.
REQ-023 The 17-bit byte counter increments on every ioctl_wr in LOAD and saturates at 17'h1FFFF without wrapping.
REQ-024 On the falling edge of ioctl_download in LOAD: if count==ROM_SIZE and there was no overflow, go to HOLD; otherwise go to ERR and set load_err.
REQ-025 HOLD: the 16-bit counter counts HOLD_CYCLES cycles, then enters RUN and sets load_done in that same transition.
REQ-026 RUN: rst_req=1 enters HOLD; HOLD restarts its count while rst_req stays high.
REQ-027 core_reset = 1 in IDLE, LOAD, HOLD and ERR; core_reset = 0 only in RUN; it is registered, glitch-free.
REQ-028 rst_req in IDLE or ERR causes no transition; rst_req during LOAD is ignored.
REQ-029 ioctl_wr outside LOAD produces no dn_we.
REQ-030 If ioctl_wr and the falling edge of ioctl_download occur in the same cycle, the byte is written and counted before the size check.

Reset
REQ-031 When reset_n=0, asynchronously: state IDLE, counters 0, dn_we=0, dn_addr=0, dn_data=0, core_reset=1, load_done=0, load_err=0, edge-detect registers 0.
REQ-032 Deassertion of reset_n mid-download leaves the block in IDLE until the next rising edge of ioctl_download; it does not resume the interrupted load.

Structure
REQ-033 Package tp_rom_pkg holds the region base/size constants, the region index enum, the state enum and ROM_SIZE.
REQ-034 One sub-module, rom_region_decode, is combinational: address in; one-hot select, relative address and out-of-range flag out.
REQ-035 Approximate size: 200 lines of RTL.

Verification
REQ-036 Scenario: download of 0xD400 sequential bytes on index 0 -> each byte appears on dn_we one cycle later with the correct one-hot and relative address (e.g. 0x7005 gives char, dn_addr=0x0005); after ioctl_download falls, core_reset stays high HOLD_CYCLES cycles, then drops and load_done=1.
REQ-037 Scenario: download of 0xD3FF bytes -> ERR, load_err=1, core_reset remains 1; a following valid download clears load_err and reaches RUN.
REQ-038 Scenario: write to 0xD400 inside an otherwise full-size download -> no dn_we for that byte, ERR at end.
REQ-039 Scenario: rst_req pulsed for 3 cycles in RUN -> core_reset high for HOLD_CYCLES+3 cycles (±1), load_done stays 1.
REQ-040 Scenario: download on index 1 with strobes -> dn_we stays 0 and state is unchanged.
REQ-041 Scenario: reset_n asserted mid-LOAD -> all outputs take reset values in the same cycle; ioctl_download falling afterwards does not leave IDLE.

Source files
------------

// File: rtl/rom_load_seq_pkg.sv
// Shared constants and types for the ROM download sequencer.
// The five regions tile the 0xD400-byte game ROM image.
package tp_rom_pkg;

  localparam logic [15:0] ROM_SIZE  = 16'hD400;

  localparam logic [15:0] CPU_BASE  = 16'h0000;
  localparam logic [15:0] SND_BASE  = 16'h6000;
  localparam logic [15:0] CHR_BASE  = 16'h7000;
  localparam logic [15:0] SPR_BASE  = 16'h9000;
  localparam logic [15:0] PROM_BASE = 16'hD000;

  localparam logic [15:0] CPU_SIZE  = 16'h6000;
  localparam logic [15:0] SND_SIZE  = 16'h1000;
  localparam logic [15:0] CHR_SIZE  = 16'h2000;
  localparam logic [15:0] SPR_SIZE  = 16'h4000;
  localparam logic [15:0] PROM_SIZE = 16'h0400;

  typedef enum logic [2:0] {
    RG_CPU,
    RG_SND,
    RG_CHR,
    RG_SPR,
    RG_PROM
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } state_e;

  function automatic logic in_rgn(
    logic [15:0] a,
    logic [15:0] base,
    logic [15:0] size
  );
    return (a >= base) && (a < base + size);
  endfunction

  function automatic logic [15:0] region_base(region_e r);
    logic [15:0] b;
    unique case (r)
      RG_SND:  b = SND_BASE;
      RG_CHR:  b = CHR_BASE;
      RG_SPR:  b = SPR_BASE;
      RG_PROM: b = PROM_BASE;
      default: b = CPU_BASE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rom_load_seq_if.sv
// Download bus from the HPS/loader side into the sequencer.
// master drives the bus, slave is the sequencer.
interface rom_load_seq_if;

  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download,
    output ioctl_index,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout
  );

  modport slave (
    input ioctl_download,
    input ioctl_index,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_dout
  );

endinterface

// File: rtl/rom_load_seq_decode.sv
// Combinational ROM region decoder: absolute byte address to
// one-hot region select, region-relative address and range flag.
module rom_region_decode
  import tp_rom_pkg::*;
(
  input  logic [15:0] addr,
  output logic [4:0]  sel,
  output logic [15:0] rel,
  output logic        oor
);

  region_e rg;

  always_comb begin
    rg  = RG_CPU;
    oor = 1'b0;
    unique case (1'b1)
      in_rgn(addr, CPU_BASE, CPU_SIZE):   rg = RG_CPU;
      in_rgn(addr, SND_BASE, SND_SIZE):   rg = RG_SND;
      in_rgn(addr, CHR_BASE, CHR_SIZE):   rg = RG_CHR;
      in_rgn(addr, SPR_BASE, SPR_SIZE):   rg = RG_SPR;
      in_rgn(addr, PROM_BASE, PROM_SIZE): rg = RG_PROM;
      default:                            oor = 1'b1;
    endcase
    sel = oor ? 5'b00000 : (5'b00001 << rg);
    rel = addr - region_base(rg);
  end

endmodule

// File: rtl/rom_load_seq.sv
// ROM download sequencer: routes download bytes to region RAMs,
// validates the image size and sequences the game core reset.
module rom_load_seq
  import tp_rom_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4096,
  parameter logic [15:0] ROM_SIZE    = tp_rom_pkg::ROM_SIZE
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  rom_load_seq_if.slave ioctl,
  input  logic          rst_req,
  output logic [15:0]   dn_addr,
  output logic [7:0]    dn_data,
  output logic [4:0]    dn_we,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_err
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_e       state_q, state_d;
  logic         dl_q, dl_d;
  logic         arm_q, arm_d;
  logic  [16:0] cnt_q, cnt_d;
  logic  [15:0] hold_q, hold_d;
  logic         ovf_q, ovf_d;
  logic  [4:0]  we_q, we_d;
  logic  [15:0] addr_q, addr_d;
  logic  [7:0]  data_q, data_d;
  logic         crst_q, crst_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic  [4:0]  sel;
  logic  [15:0] rel;
  logic         oor;
  logic         start;
  logic         dl_fall;
  logic         hit;

  rom_region_decode u_dec (
    .addr (ioctl.ioctl_addr[15:0]),
    .sel  (sel),
    .rel  (rel),
    .oor  (oor)
  );

  // arm_q blocks a download left high across reset from restarting a load
  assign start   = ioctl.ioctl_download & ~dl_q & arm_q
                 & (ioctl.ioctl_index == 8'h00);
  assign dl_fall = ~ioctl.ioctl_download & dl_q;
  assign hit     = (ioctl.ioctl_addr[24:16] == 9'd0) & ~oor
                 & (ioctl.ioctl_addr[15:0] < ROM_SIZE);

  always_comb begin
    state_d = state_q;
    dl_d    = ioctl.ioctl_download;
    arm_d   = arm_q | ~ioctl.ioctl_download;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    we_d    = 5'b00000;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (ioctl.ioctl_wr) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 17'd1;
            if (hit) begin
              we_d   = sel;
              addr_d = rel;
              data_d = ioctl.ioctl_dout;
            end else begin
              ovf_d = 1'b1;
            end
          end
          // a strobe in the falling-edge cycle is counted first
          if (dl_fall) begin
            if (cnt_d == {1'b0, ROM_SIZE} && !ovf_d) begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end else begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (rst_req) begin
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (rst_req) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end
        default: ;
      endcase
    end
    crst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dl_q    <= 1'b0;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dn_we      = we_q;
  assign dn_addr    = addr_q;
  assign dn_data    = data_q;
  assign core_reset = crst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule
